// File: rtl/regs_if.sv
// regs_if: writeback (LSU -> regs) and operand-read (IDU <-> regs) signals of the RV32 register file.
// master = LSU/IDU side, slave = register file.
interface regs_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          rd_we_i;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_data_i;
    logic          rs1_re_i;
    logic [AW-1:0] rs1_addr_i;
    logic [DW-1:0] rs1_data_o;
    logic          rs2_re_i;
    logic [AW-1:0] rs2_addr_i;
    logic [DW-1:0] rs2_data_o;
    logic [DW-1:0] wb_cnt_o;

    modport master (
        output rd_we_i, rd_addr_i, rd_data_i,
        output rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i,
        input  rs1_data_o, rs2_data_o, wb_cnt_o
    );

    modport slave (
        input  rd_we_i, rd_addr_i, rd_data_i,
        input  rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i,
        output rs1_data_o, rs2_data_o, wb_cnt_o
    );
endinterface

// File: rtl/regs.sv
// regs: RV32 register file, x1-x31 in flops (x0 reads 0), two combinational read ports and a
// committed-write counter. Define REGS_BYPASS_EN to forward a same-cycle write to the read ports.
module regs #(
    parameter int unsigned REG_NUM = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    regs_if.slave bus
);
    localparam int unsigned DW = 32;

`ifdef REGS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DW-1:0] regs_q [1:REG_NUM-1];
    logic [DW-1:0] regs_d [1:REG_NUM-1];
    logic [DW-1:0] wb_cnt_q;
    logic [DW-1:0] wb_cnt_d;
    logic          commit;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;

    assign commit = bus.rd_we_i && (bus.rd_addr_i != '0);

    always_comb begin
        regs_d   = regs_q;
        wb_cnt_d = wb_cnt_q;
        if (commit) begin
            regs_d[bus.rd_addr_i] = bus.rd_data_i;
            wb_cnt_d              = wb_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '{default: '0};
            wb_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    // The forward mux folds away when BYPASS is 0, leaving a plain array read.
    always_comb begin
        rs1_data = '0;
        if (rst_n && bus.rs1_re_i && (bus.rs1_addr_i != '0)) begin
            if (BYPASS && bus.rd_we_i && (bus.rd_addr_i == bus.rs1_addr_i)) begin
                rs1_data = bus.rd_data_i;
            end else begin
                rs1_data = regs_q[bus.rs1_addr_i];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rst_n && bus.rs2_re_i && (bus.rs2_addr_i != '0)) begin
            if (BYPASS && bus.rd_we_i && (bus.rd_addr_i == bus.rs2_addr_i)) begin
                rs2_data = bus.rd_data_i;
            end else begin
                rs2_data = regs_q[bus.rs2_addr_i];
            end
        end
    end

    assign bus.rs1_data_o = rs1_data;
    assign bus.rs2_data_o = rs2_data;
    assign bus.wb_cnt_o   = wb_cnt_q;
endmodule

// File: tb/tb_regs.sv
// tb_regs: table-driven vectors, directed reset/bypass/wrap sequences and a randomized run
// against an array-based model of the register file.
module tb_regs;
`ifdef REGS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    regs_if #(.DW(32), .AW(5)) bus ();
    regs #(.REG_NUM(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  a1;
        logic        re2;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ecnt;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] model [32];
    logic [31:0] mcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re1, input logic [4:0] a1,
                         input logic re2, input logic [4:0] a2);
        bus.rd_we_i    = we;
        bus.rd_addr_i  = wa;
        bus.rd_data_i  = wd;
        bus.rs1_re_i   = re1;
        bus.rs1_addr_i = a1;
        bus.rs2_re_i   = re2;
        bus.rs2_addr_i = a2;
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (!rst_n || !re || a == 5'd0) return 32'h0;
        if (BYPASS && bus.rd_we_i && bus.rd_addr_i == a) return bus.rd_data_i;
        return model[a];
    endfunction

    initial begin
        tbl[0] = '{1'b1, 5'd1,  32'h11111111, 1'b0, 5'd1,  1'b1, 5'd0,  32'h0,        32'h0,        32'd1};
        tbl[1] = '{1'b1, 5'd31, 32'hFFFF0000, 1'b1, 5'd1,  1'b0, 5'd31, 32'h11111111, 32'h0,        32'd2};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b1, 5'd31, 32'h11111111, 32'hFFFF0000, 32'd2};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd31, 32'hFFFF0000, 32'hFFFF0000, 32'd2};
        tbl[4] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b1, 5'd1,  32'h0,        32'h11111111, 32'd2};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        32'd2};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  1'b1, 5'd5,  32'h0,        32'h0,        32'd2};
        tbl[7] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd31, 1'b0, 5'd5,  32'hFFFF0000, 32'h0,        32'd3};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'd3};

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rs1", bus.rs1_data_o, 32'h0);
        check("reset_rs2", bus.rs2_data_o, 32'h0);
        check("reset_cnt", bus.wb_cnt_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re1, tbl[i].a1, tbl[i].re2, tbl[i].a2);
            #1;
            check($sformatf("tbl%0d_rs1", i), bus.rs1_data_o, tbl[i].e1);
            check($sformatf("tbl%0d_rs2", i), bus.rs2_data_o, tbl[i].e2);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_cnt", i), bus.wb_cnt_o, tbl[i].ecnt);
        end

        // Same-cycle read of the register being written, and x0 write with x0 read.
        @(negedge clk);
        drive(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 1'b1, 5'd0);
        #1;
        check("byp_rs1", bus.rs1_data_o, BYPASS ? 32'hB : 32'hA);
        check("byp_rs2_x0", bus.rs2_data_o, 32'h0);
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hCAFE, 1'b1, 5'd7, 1'b1, 5'd0);
        #1;
        check("byp_next_rs1", bus.rs1_data_o, 32'hB);
        check("byp_x0_rs2", bus.rs2_data_o, 32'h0);
        @(posedge clk);
        #1;
        check("byp_cnt", bus.wb_cnt_o, 32'd5);

        // Asynchronous reset clears reads immediately.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        check("pre_rst_x5", bus.rs1_data_o, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_x5", bus.rs1_data_o, 32'h0);
        check("rst_cnt", bus.wb_cnt_o, 32'h0);

        // Writes presented while reset is held never commit.
        drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
        rst_n = 1'b1;
        #1;
        check("rstwr_x3", bus.rs1_data_o, 32'h0);
        check("rstwr_cnt", bus.wb_cnt_o, 32'h0);
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 1'b1, 5'(32 - r));
            #1;
            check($sformatf("clr_x%0d", r), bus.rs1_data_o, 32'h0);
            check($sformatf("clr_x%0d_p2", 32 - r), bus.rs2_data_o, 32'h0);
        end

        // Counter wrap: preload near the top, then three commits.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        force dut.wb_cnt_d = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.wb_cnt_d;
        check("wrap_preload", bus.wb_cnt_o, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd2, 32'(k), 1'b0, 5'd0, 1'b0, 5'd0);
            @(posedge clk);
            #1;
            check($sformatf("wrap_%0d", k), bus.wb_cnt_o, 32'hFFFF_FFFF + 32'(k));
        end

        // Randomized traffic against the array model, starting from a clean reset.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        mcnt = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  $urandom_range(0, 5) != 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 5) != 0,
                  ($urandom_range(0, 3) == 0) ? bus.rd_addr_i : 5'($urandom_range(0, 31)));
            #1;
            check("rnd_rs1", bus.rs1_data_o, model_read(bus.rs1_re_i, bus.rs1_addr_i));
            check("rnd_rs2", bus.rs2_data_o, model_read(bus.rs2_re_i, bus.rs2_addr_i));
            if (bus.rd_we_i && bus.rd_addr_i != 5'd0) begin
                model[bus.rd_addr_i] = bus.rd_data_i;
                mcnt = mcnt + 32'd1;
            end
            @(posedge clk);
            #1;
            check("rnd_cnt", bus.wb_cnt_o, mcnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regs.md
# regs

Architectural integer register file for the RV32 core: 32 × 32-bit registers written by the writeback path from the LSU and read combinationally by the IDU through two read ports. Sits directly downstream of the LSU and consumes its `rd_we`/`rd_addr`/`rd_data` result. Also keeps a committed-write counter used by debug and performance logic.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers. Fixed for RV32I.
- Data width is `REG_BUS` (32 bits) and address width is `REG_ADDR_BUS` (5 bits), both from `defines.v`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_we_i`  in  1  write enable from the LSU.
- `rd_addr_i`  in  `REG_ADDR_BUS`  destination register index from the LSU.
- `rd_data_i`  in  `REG_BUS`  write data from the LSU.
- `rs1_re_i`  in  1  read enable, port 1, from the IDU.
- `rs1_addr_i`  in  `REG_ADDR_BUS`  read index, port 1.
- `rs1_data_o`  out  `REG_BUS`  read data, port 1.
- `rs2_re_i`  in  1  read enable, port 2, from the IDU.
- `rs2_addr_i`  in  `REG_ADDR_BUS`  read index, port 2.
- `rs2_data_o`  out  `REG_BUS`  read data, port 2.
- `wb_cnt_o`  out  `REG_BUS`  count of committed register writes.

## Operation
- **Storage:** registers x1–x31 are flops. x0 is not stored and always reads 0.
- **Write:** at a rising edge of `clk`, if `rd_we_i`=1 and `rd_addr_i`≠0, then `regs[rd_addr_i]` ← `rd_data_i`.
  - Writes to x0 are discarded.
- **Read:** purely combinational, port n (n = 1, 2). Priority, highest first:
  - `rst_n`=0 → 0.
  - `rsn_re_i`=0 → 0.
  - `rsn_addr_i`=0 → 0.
  - Bypass hit (only when `REGS_BYPASS_EN` is defined): `rd_we_i`=1 and `rd_addr_i`=`rsn_addr_i` → `rd_data_i`.
  - Otherwise → `regs[rsn_addr_i]`.
- **Dual-port reads:** both ports may address the same register in the same cycle. Both return identical data.
- **Write counter:** `wb_cnt_o` increments by 1 on every edge where a write commits (`rd_we_i`=1, `rd_addr_i`≠0).
  - Writes to x0 do not count.
  - Wraps from 0xFFFF_FFFF to 0x0000_0000 with no flag.
- **Reset:** `rst_n` low immediately clears x1–x31 and `wb_cnt_o` to 0.
  - A write presented on the same edge that reset deasserts is ignored only if `rst_n` is still sampled low.
  - A write asserted mid-reset is never committed.

## Timing
- **Reset values:** `rs1_data_o`=0, `rs2_data_o`=0, `wb_cnt_o`=0. All registers read 0 after reset until written.
- **Write latency:** 1 cycle. Data presented at edge N is visible through the array path after edge N.
- **Read latency:** 0 cycles, combinational from address/enable to data. There is no registered output.
- **Same-cycle read of the register being written:**
  - With bypass: new data, 0-cycle forward.
  - Without bypass: old data. The IDU hazard logic must stall one cycle.
- **Write timing:** exactly one write per cycle, no back-pressure. The LSU result is always accepted.
- **Counter timing:** `wb_cnt_o` updates on the same edge as the commit. It reads the new count from the cycle after.

## Configuration
- **Macro:** `REGS_BYPASS_EN`.
- **Defined:** the write-to-read forwarding mux is built on both read ports. A same-cycle read-after-write returns `rd_data_i`. The forward path is suppressed for x0 and during reset.
- **Undefined:** no forwarding mux. Reads always return the stored array value, i.e. pre-write data for a same-cycle hit. The read path shortens by one mux level.

## Test plan
- **Reset clear:** write 0xDEADBEEF to x5, assert `rst_n`=0 mid-cycle → `rs1_data_o` reads 0 for x5 immediately. After release `wb_cnt_o`=0 and all of x1–x31 read 0.
- **Write/read both ports:** write x1=0x11111111 and x31=0xFFFF0000 on consecutive cycles, then read rs1=x1 and rs2=x31 → 0x11111111 and 0xFFFF0000. Read rs1=rs2=x31 → both 0xFFFF0000. `wb_cnt_o`=2.
- **x0 and read-enable:** write x0=0x12345678 → rs1=x0 reads 0 and `wb_cnt_o` is unchanged. Read x1 with `rs1_re_i`=0 → 0.
- **Bypass:** x7 holds 0xA, same-cycle write x7=0xB with rs1=x7.
  - With `REGS_BYPASS_EN`: `rs1_data_o`=0xB.
  - Without: `rs1_data_o`=0xA, then 0xB the next cycle.
  - Writing x0 with rs2=x0 → 0 in both builds.
- **Counter wrap:** force the counter to 0xFFFF_FFFE and commit 3 writes → 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- **Write during reset:** hold `rst_n`=0 with `rd_we_i`=1 writing x3=0x55 over 3 edges, then release → x3 reads 0 and `wb_cnt_o`=0.
